ym_bus_responder: RTL and testbench
===================================

# ym_bus_responder

Bus-side responder for the YM2203-style host write interface (`cs_n`/`wr_n`/`rd_n`/`addr`/`din`) driven by the register-sequencing blocks. It decodes two-phase writes (address phase with `addr`=0, data phase with `addr`=1) and queues each completed register write as an {address, data} pair in a small FIFO with a valid/ready output. It also models the chip's busy window and returns status on reads. It sits between a host-side write sequencer and any consumer of register writes: a register-file shadow, a logger, or a checker.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `BUSY_CYCLES`, 32: `cen` ticks that busy stays asserted after each accepted data write; 1..255.

Ports:
- `clk_in` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `cen` in 1: clock enable. Bus sampling, the busy counter and `dout` updates occur only when `cen`=1.
- `cs_n` in 1: chip select, active-low.
- `wr_n` in 1: write strobe, active-low.
- `rd_n` in 1: read strobe, active-low.
- `addr` in 1: 0 selects address phase or status; 1 selects the data phase.
- `din` in 8: write data.
- `dout` out 8: status byte.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: consumer accepts the head.
- `out_addr` out 8: register address of the head entry.
- `out_data` out 8: register data of the head entry.
- `level` out log2(DEPTH)+1: FIFO occupancy.
- `busy` out 1: busy window active.

## Operation
- **Write strobe.** `wstb` = `cen` & !`cs_n` & !`wr_n` & `wr_q`.
  - `wr_q` is a registered copy of (`cs_n`|`wr_n`), updated on `cen` cycles. Its reset value is 1.
  - One write is accepted per low pulse, however long the pulse is held.
- **Address phase** (`wstb` & `addr`=0): `areg` <= `din`. Nothing is queued.
- **Data phase** (`wstb` & `addr`=1): push {`areg`, `din`} into the FIFO and load the busy counter with BUSY_CYCLES.
  - `areg` keeps its value, so repeated data writes go to the same address.
  - `areg` resets to 8'h00. A data write with no prior address write queues address 8'h00.
- **Busy.**
  - The counter decrements on each `cen` cycle while nonzero.
  - `busy` = (counter != 0).
  - A data write while `busy`=1 is still queued, restarts the counter, and sets sticky `viol`.
  - Address writes do not affect `busy`.
- **FIFO.**
  - Pop = `out_valid` & `out_ready`, on any clock; it is not gated by `cen`.
  - Push when not full, or when full with a pop in the same cycle. Both then happen and `level` is unchanged.
  - Push when full with no pop: the entry is dropped, sticky `ovf` is set, and the busy counter still reloads.
  - Push into an empty FIFO: `out_valid` rises the next cycle. There is no bypass.
  - Pointers wrap modulo DEPTH.
  - `out_addr`/`out_data` hold the head entry and are don't-care when `out_valid`=0.
- **Read** (`cen` & !`cs_n` & !`rd_n`):
  - `dout` <= {`busy`, 5'b0, `ovf`, `viol`}, registered.
  - A read with `addr`=0 also clears `ovf` and `viol` after they are sampled into `dout`. If a set event occurs in the same cycle, set wins.
  - A read with `addr`=1 updates `dout` without clearing the flags.
  - `dout` holds its value otherwise.
- **Simultaneous strobes.** With `wr_n` and `rd_n` both low, the write is processed and the read is ignored.

## Timing
- **Reset values:**
  - `dout` = 8'h00, `out_valid` = 0, `level` = 0, `busy` = 0.
  - `areg` = 8'h00, `ovf` = `viol` = 0, busy counter = 0, `wr_q` = 1.
  - `out_addr`/`out_data` = 8'h00.
- **Reset mid-operation:** FIFO contents are discarded and any partial address/data sequence is forgotten.
- **Data write to output:** `wstb` at edge N gives `out_valid`=1 and `level` incremented after edge N.
- **Busy window:**
  - `busy`=1 after edge N.
  - It falls after BUSY_CYCLES further `cen` edges.
  - With `cen` tied high, it falls after edge N+BUSY_CYCLES.
- **Status read:** `dout` is valid the cycle after the read strobe is sampled.
- **Bus rule:** `din`/`addr` must be valid in the same cycle as the `wr_n` low sample; the block is the responder for a same-clock driver.

## Test plan
- **Basic write.** `cen`=1; write 8'hB0 (`addr`=0), then 8'h07 (`addr`=1). Required: one entry {B0,07}; `out_valid` after the data edge; `busy`=1 for 32 cycles.
- **Held strobe.** `wr_n` low for 5 cycles with `addr`=1 and `din`=8'h3B. Required: exactly one FIFO entry.
- **Overflow.**
  - `out_ready`=0, DEPTH=4; five data writes. Required: `level`=4 and the status read shows `dout`=8'h82 (busy, ovf).
  - Second read with `addr`=0. Required: `dout`[1]=0.
- **Full with simultaneous pop.** FIFO full; assert `out_ready` in the same cycle as a data write. Required: `level` stays 4 and entry order is preserved, with the oldest entry popped first.
- **Busy violation.** Data write at t, second data write at t+10. Required: `viol`=1 and `busy` held until t+10+32.
- **Reset and cen gating.**
  - Assert `rst` with 3 entries queued. Required: all outputs at reset values the next cycle.
  - `cen`=0 during a write pulse. Required: nothing is queued.

Source files
------------

// File: rtl/ym_bus_responder.sv
// YM2203-style bus responder: decodes two-phase register writes into an
// {addr,data} FIFO, models the busy window and returns sticky status on reads.
module ym_bus_responder #(
  parameter int DEPTH       = 4,
  parameter int BUSY_CYCLES = 32
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic                     cen,
  input  logic                     cs_n,
  input  logic                     wr_n,
  input  logic                     rd_n,
  input  logic                     addr,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_addr,
  output logic [7:0]               out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic          r_wr_q;
  logic [7:0]    r_areg;
  logic [7:0]    r_cnt;
  logic          r_ovf;
  logic          r_viol;
  logic [7:0]    r_dout;
  logic [7:0]    r_mem_addr [DEPTH];
  logic [7:0]    r_mem_data [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  logic w_wstb, w_push, w_pop, w_full, w_push_ok, w_ovf_set, w_viol_set;
  logic w_rd, w_clr;

  // Edge-detect the write strobe so a held low pulse yields one write.
  assign w_wstb     = cen & ~cs_n & ~wr_n & r_wr_q;
  assign w_push     = w_wstb & addr;
  assign w_pop      = out_valid & out_ready;
  assign w_full     = (r_level == LW'(DEPTH));
  assign w_push_ok  = w_push & (~w_full | w_pop);
  assign w_ovf_set  = w_push & w_full & ~w_pop;
  assign w_viol_set = w_push & busy;
  // A simultaneous write strobe takes precedence over the read.
  assign w_rd       = cen & ~cs_n & ~rd_n & wr_n;
  assign w_clr      = w_rd & ~addr;

  assign busy      = (r_cnt != 8'd0);
  assign out_valid = (r_level != '0);
  assign level     = r_level;
  assign dout      = r_dout;
  assign out_addr  = r_mem_addr[r_rd_ptr];
  assign out_data  = r_mem_data[r_rd_ptr];

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_wr_q   <= 1'b1;
      r_areg   <= 8'h00;
      r_cnt    <= 8'd0;
      r_ovf    <= 1'b0;
      r_viol   <= 1'b0;
      r_dout   <= 8'h00;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_addr[i] <= 8'h00;
        r_mem_data[i] <= 8'h00;
      end
    end else begin
      if (cen) r_wr_q <= cs_n | wr_n;
      if (w_wstb && !addr) r_areg <= din;

      if (w_push_ok) begin
        r_mem_addr[r_wr_ptr] <= r_areg;
        r_mem_data[r_wr_ptr] <= din;
        r_wr_ptr             <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase

      // Every data write reloads the window, even when the entry is dropped.
      if (w_push)                   r_cnt <= 8'(BUSY_CYCLES);
      else if (cen && r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;

      if (w_rd) r_dout <= {busy, 5'b0, r_ovf, r_viol};

      if (w_ovf_set)  r_ovf  <= 1'b1;
      else if (w_clr) r_ovf  <= 1'b0;
      if (w_viol_set) r_viol <= 1'b1;
      else if (w_clr) r_viol <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ym_bus_responder.sv
// Directed bench for ym_bus_responder: basic write, held strobe, overflow,
// full-with-pop, busy violation, reset and cen gating.
module tb_ym_bus_responder;
  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b1;
  logic       cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1, addr = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout, out_addr, out_data;
  logic       out_valid, out_ready = 1'b0, busy;
  logic [2:0] level;
  int         n_cmp = 0, n_bad = 0;

  ym_bus_responder #(.DEPTH(4), .BUSY_CYCLES(32)) dut (
    .clk_in(clk_in), .rst(rst), .cen(cen), .cs_n(cs_n), .wr_n(wr_n),
    .rd_n(rd_n), .addr(addr), .din(din), .dout(dout), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .level(level), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Strobe held for one sampled edge; returns just after that edge.
  task automatic bus_write(input logic a, input logic [7:0] d, input logic rdy);
    cs_n = 0; wr_n = 0; addr = a; din = d; out_ready = rdy;
    tick();
    cs_n = 1; wr_n = 1; out_ready = 0;
  endtask

  task automatic bus_read(input logic a);
    cs_n = 0; rd_n = 0; addr = a;
    tick();
    cs_n = 1; rd_n = 1;
  endtask

  task automatic pop_one();
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy; i++) tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL wait_idle: busy=%b required 0 within 300 cycles", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick(); rst = 0;
    n_cmp++;
    if ({dout, out_valid, level, busy, out_addr, out_data} !== 29'h0) begin
      n_bad++;
      $display("FAIL reset: dout=%h valid=%b level=%0d busy=%b oa=%h od=%h required all zero",
               dout, out_valid, level, busy, out_addr, out_data);
    end
  endtask

  task automatic test_basic();
    bus_write(0, 8'hB0, 0); tick();
    bus_write(1, 8'h07, 0);
    n_cmp++;
    if ({out_valid, level, busy, out_addr, out_data} !== {1'b1, 3'd1, 1'b1, 8'hB0, 8'h07}) begin
      n_bad++;
      $display("FAIL basic_entry: valid=%b level=%0d busy=%b oa=%h od=%h required 1 1 1 b0 07",
               out_valid, level, busy, out_addr, out_data);
    end
    for (int i = 1; i <= 31; i++) begin
      tick();
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_hold: cycle %0d busy=%b required 1", i, busy); end
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_fall: busy=%b required 0", busy); end
    pop_one();
    n_cmp++;
    if ({out_valid, level} !== 4'b0_000) begin
      n_bad++; $display("FAIL basic_pop: valid=%b level=%0d required 0 0", out_valid, level);
    end
  endtask

  task automatic test_held();
    cs_n = 0; wr_n = 0; addr = 1; din = 8'h3B;
    repeat (5) tick();
    cs_n = 1; wr_n = 1;
    tick();
    n_cmp++;
    if ({level, out_addr, out_data} !== {3'd1, 8'hB0, 8'h3B}) begin
      n_bad++; $display("FAIL held_strobe: level=%0d oa=%h od=%h required 1 b0 3b", level, out_addr, out_data);
    end
    pop_one();
  endtask

  task automatic test_overflow();
    wait_idle();
    bus_read(0);
    for (int k = 1; k <= 5; k++) begin
      bus_write(1, 8'(k), 0); tick();
      if (k < 5) wait_idle();
    end
    bus_read(0);
    n_cmp++;
    if (level !== 3'd4) begin n_bad++; $display("FAIL ovf_level: level=%0d required 4", level); end
    n_cmp++;
    if (dout !== 8'h82) begin n_bad++; $display("FAIL ovf_status: dout=%h required 82", dout); end
    bus_read(0);
    n_cmp++;
    if (dout !== 8'h80) begin n_bad++; $display("FAIL ovf_cleared: dout=%h required 80", dout); end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h02; exp_d[1] = 8'h03; exp_d[2] = 8'h04; exp_d[3] = 8'h06;
    bus_write(1, 8'h06, 1);
    n_cmp++;
    if ({level, out_data} !== {3'd4, 8'h02}) begin
      n_bad++; $display("FAIL full_pop: level=%0d head=%h required 4 02", level, out_data);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (out_data !== exp_d[i]) begin
        n_bad++; $display("FAIL full_pop_order: entry %0d data=%h required %h", i, out_data, exp_d[i]);
      end
      pop_one();
    end
    n_cmp++;
    if (level !== 3'd0) begin n_bad++; $display("FAIL full_pop_drain: level=%0d required 0", level); end
  endtask

  task automatic test_violation();
    wait_idle();
    bus_read(0);
    bus_write(1, 8'h21, 0);
    repeat (9) tick();
    bus_write(1, 8'h22, 0);
    for (int i = 1; i <= 31; i++) begin
      tick();
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL viol_busy_hold: cycle %0d busy=%b required 1", i, busy); end
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL viol_busy_fall: busy=%b required 0", busy); end
    bus_read(1);
    n_cmp++;
    if (dout !== 8'h01) begin n_bad++; $display("FAIL viol_status: dout=%h required 01", dout); end
    bus_read(0);
    n_cmp++;
    if (dout !== 8'h01) begin n_bad++; $display("FAIL viol_no_clear_a1: dout=%h required 01", dout); end
    bus_read(1);
    n_cmp++;
    if (dout !== 8'h00) begin n_bad++; $display("FAIL viol_clear_a0: dout=%h required 00", dout); end
    n_cmp++;
    if (out_data !== 8'h21) begin n_bad++; $display("FAIL viol_entry0: data=%h required 21", out_data); end
    pop_one();
    n_cmp++;
    if (out_data !== 8'h22) begin n_bad++; $display("FAIL viol_entry1: data=%h required 22", out_data); end
    pop_one();
  endtask

  task automatic test_reset_cen();
    for (int k = 0; k < 3; k++) begin bus_write(1, 8'(8'h31 + k), 0); tick(); end
    bus_write(0, 8'hAA, 0); tick();
    rst = 1; tick(); rst = 0;
    n_cmp++;
    if ({dout, out_valid, level, busy, out_addr, out_data} !== 29'h0) begin
      n_bad++;
      $display("FAIL mid_reset: dout=%h valid=%b level=%0d busy=%b oa=%h od=%h required all zero",
               dout, out_valid, level, busy, out_addr, out_data);
    end
    cen = 0; cs_n = 0; wr_n = 0; addr = 1; din = 8'h77;
    tick(); tick();
    cs_n = 1; wr_n = 1; cen = 1;
    tick(); tick();
    n_cmp++;
    if ({level, busy} !== 4'b000_0) begin
      n_bad++; $display("FAIL cen_gate: level=%0d busy=%b required 0 0", level, busy);
    end
    bus_write(1, 8'h55, 0);
    n_cmp++;
    if ({level, out_addr, out_data} !== {3'd1, 8'h00, 8'h55}) begin
      n_bad++; $display("FAIL areg_after_reset: level=%0d oa=%h od=%h required 1 00 55", level, out_addr, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_held();
    test_overflow();
    test_full_pop();
    test_violation();
    test_reset_cen();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
